// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - seven-segment bus receiver with glitch filter and frame assembly
// Optional decimal-to-binary conversion is compiled in with SEG_CAPTURE_BIN_EN.
module seg_capture #(
  parameter int SETTLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_l,
  input  logic        b_l,
  input  logic        c_l,
  input  logic        d_l,
  input  logic        e_l,
  input  logic        f_l,
  input  logic        g_l,
  input  logic        dig1,
  input  logic        dig2,
  input  logic        dig3,
  input  logic        dig4,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  C,
  output logic [3:0]  D,
  output logic [3:0]  bad,
  output logic        frame_done,
  output logic        err_multi,
  output logic [13:0] value,
  output logic        value_valid
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] SETTLE_CNT  = 8'(SETTLE);

  logic [10:0] pins, sync1, sync2;
  logic [6:0]  seg, seg_prev;
  logic [3:0]  strb, strb_prev;
  logic        changed, multi, onehot;
  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        cap;
  logic [4:0]  cap_word;
  logic [4:0]  stg [4];
  logic [3:0]  mask, mask_nxt;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: decode = 5'h00;
      7'b0110000: decode = 5'h01;
      7'b1101101: decode = 5'h02;
      7'b1111001: decode = 5'h03;
      7'b0110011: decode = 5'h04;
      7'b1011011: decode = 5'h05;
      7'b1011111: decode = 5'h06;
      7'b1110000: decode = 5'h07;
      7'b1111111: decode = 5'h08;
      7'b1111011: decode = 5'h09;
      7'b1110111: decode = 5'h0a;
      7'b0011111: decode = 5'h0b;
      7'b1001110: decode = 5'h0c;
      7'b0111101: decode = 5'h0d;
      7'b1001111: decode = 5'h0e;
      7'b1000111: decode = 5'h0f;
      default:    decode = 5'h10;
    endcase
  endfunction

  assign pins    = {a_l, b_l, c_l, d_l, e_l, f_l, g_l, dig1, dig2, dig3, dig4};
  assign seg     = ~sync2[10:4];
  assign strb    = ~sync2[3:0];
  assign changed = (seg != seg_prev) || (strb != strb_prev);
  assign multi   = |(strb & (strb - 4'd1));
  assign onehot  = (strb != 4'd0) && !multi;
  assign cap_word = decode(seg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= '1;
      sync2     <= '1;
      seg_prev  <= '0;
      strb_prev <= '0;
    end else begin
      sync1     <= pins;
      sync2     <= sync1;
      seg_prev  <= seg;
      strb_prev <= strb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Losing one-hot (blank or overlap) always returns to IDLE, so multi-strobe never captures.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = 8'd0;
        if (onehot) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = 8'd1;
        end
      end
      ST_SETTLE: begin
        if (!onehot) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 8'd0;
        end else if (changed) begin
          cnt_nxt = 8'd1;
        end else if (cnt == SETTLE_LAST) begin
          cnt_nxt   = SETTLE_CNT;
          cap       = 1'b1;
          state_nxt = ST_HOLD;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_HOLD: begin
        if (!onehot) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 8'd0;
        end else if (changed) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = 8'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  assign mask_nxt = ((mask == 4'hf) ? 4'h0 : mask) | (cap ? strb : 4'h0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) stg[i] <= 5'd0;
      mask       <= 4'h0;
      A          <= 4'd0;
      B          <= 4'd0;
      C          <= 4'd0;
      D          <= 4'd0;
      bad        <= 4'd0;
      frame_done <= 1'b0;
      err_multi  <= 1'b0;
    end else begin
      err_multi  <= multi;
      frame_done <= 1'b0;
      mask       <= mask_nxt;
      for (int i = 0; i < 4; i++) begin
        if (cap && strb[i]) stg[i] <= cap_word;
      end
      if (mask == 4'hf) begin
        A          <= stg[3][3:0];
        B          <= stg[2][3:0];
        C          <= stg[1][3:0];
        D          <= stg[0][3:0];
        bad        <= {stg[3][4], stg[2][4], stg[1][4], stg[0][4]};
        frame_done <= 1'b1;
      end
    end
  end

`ifdef SEG_CAPTURE_BIN_EN
  logic        busy;
  logic [1:0]  step;
  logic [13:0] acc, acc_step;
  logic [3:0]  dsel;
  logic        frame_ok;

  assign frame_ok = frame_done && (bad == 4'd0) &&
                    (A <= 4'd9) && (B <= 4'd9) && (C <= 4'd9) && (D <= 4'd9);

  always_comb begin
    dsel = A;
    case (step)
      2'd0:    dsel = A;
      2'd1:    dsel = B;
      2'd2:    dsel = C;
      default: dsel = D;
    endcase
  end

  assign acc_step = acc * 14'd10 + {10'd0, dsel};

  // A..D stay stable for the four steps because frames are at least 16 cycles apart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        <= 1'b0;
      step        <= 2'd0;
      acc         <= 14'd0;
      value       <= 14'd0;
      value_valid <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      if (frame_ok) begin
        busy <= 1'b1;
        step <= 2'd0;
        acc  <= 14'd0;
      end else if (busy) begin
        acc  <= acc_step;
        step <= step + 2'd1;
        if (step == 2'd3) begin
          busy        <= 1'b0;
          value       <= acc_step;
          value_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign value       = 14'd0;
  assign value_valid = 1'b0;
`endif

endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - scoreboard bench for seg_capture
module tb_seg_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_l, b_l, c_l, d_l, e_l, f_l, g_l;
  logic        dig1, dig2, dig3, dig4;
  logic [3:0]  A, B, C, D, bad;
  logic        frame_done, err_multi, value_valid;
  logic [13:0] value;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  bad;
  } frame_t;

  frame_t exp_q[$];
  int     exp_v[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     n_frames = 0;
  int     n_multi = 0;
  int     fd_age = 0;
  int     exp_value = 0;

  seg_capture #(.SETTLE(16)) dut (
    .clk(clk), .rst(rst),
    .a_l(a_l), .b_l(b_l), .c_l(c_l), .d_l(d_l), .e_l(e_l), .f_l(f_l), .g_l(g_l),
    .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4),
    .A(A), .B(B), .C(C), .D(D), .bad(bad),
    .frame_done(frame_done), .err_multi(err_multi),
    .value(value), .value_valid(value_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pat7(input int n);
    case (n)
      0:  pat7 = 7'b1111110;  1:  pat7 = 7'b0110000;
      2:  pat7 = 7'b1101101;  3:  pat7 = 7'b1111001;
      4:  pat7 = 7'b0110011;  5:  pat7 = 7'b1011011;
      6:  pat7 = 7'b1011111;  7:  pat7 = 7'b1110000;
      8:  pat7 = 7'b1111111;  9:  pat7 = 7'b1111011;
      10: pat7 = 7'b1110111;  11: pat7 = 7'b0011111;
      12: pat7 = 7'b1001110;  13: pat7 = 7'b0111101;
      14: pat7 = 7'b1001111;  default: pat7 = 7'b1000111;
    endcase
  endfunction

  // Must be entered at a negedge; holds the pattern for exactly `cycles` clocks.
  task automatic drive(input logic [3:0] sel, input logic [6:0] p, input int cycles);
    {dig1, dig2, dig3, dig4} = ~sel;
    {a_l, b_l, c_l, d_l, e_l, f_l, g_l} = ~p;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic expect_frame(input int d3, input int d2, input int d1, input int d0,
                              input logic [3:0] b, input bit want_value);
    frame_t f;
    f.d   = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
    f.bad = b;
    exp_q.push_back(f);
`ifdef SEG_CAPTURE_BIN_EN
    if (want_value && b == 4'd0 && d3 <= 9 && d2 <= 9 && d1 <= 9 && d0 <= 9) begin
      exp_value = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
      exp_v.push_back(exp_value);
    end
`endif
  endtask

  task automatic send4(input int d3, input int d2, input int d1, input int d0, input int dwell);
    drive(4'b1000, pat7(d3), dwell);
    drive(4'b0100, pat7(d2), dwell);
    drive(4'b0010, pat7(d1), dwell);
    drive(4'b0001, pat7(d0), dwell);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && exp_v.size() == 0) break;
      @(negedge clk);
    end
    check(tag, exp_q.size() + exp_v.size(), 0);
    repeat (10) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (err_multi) n_multi++;
    if (frame_done) fd_age = 0;
    else fd_age++;
    if (frame_done) begin
      n_frames++;
      if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
      else begin
        frame_t f;
        f = exp_q.pop_front();
        check("frame_A", A, f.d[15:12]);
        check("frame_B", B, f.d[11:8]);
        check("frame_C", C, f.d[7:4]);
        check("frame_D", D, f.d[3:0]);
        check("frame_bad", bad, f.bad);
      end
    end
    if (value_valid) begin
      check("value_latency", fd_age, 5);
      if (exp_v.size() == 0) check("value_valid_unexpected", 1, 0);
      else check("value", value, exp_v.pop_front());
    end
  end

  initial begin
    int m0, f0;
    bit seen;
    rst = 1'b0;
    {a_l, b_l, c_l, d_l, e_l, f_l, g_l} = '1;
    {dig1, dig2, dig3, dig4} = '1;
    repeat (5) @(negedge clk);
    check("rst_A", A, 0);
    check("rst_D", D, 0);
    check("rst_bad", bad, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_multi", err_multi, 0);
    check("rst_value", value, 0);
    check("rst_value_valid", value_valid, 0);
    rst = 1'b1;
    @(negedge clk);

    // static decimal frame
    expect_frame(1, 2, 3, 4, 4'b0000, 1'b1);
    send4(1, 2, 3, 4, 1000);
    drain("static_drain");
    check("static_value", value, exp_value);

    // hex frame: no conversion, value retained
    expect_frame(10, 11, 12, 13, 4'b0000, 1'b1);
    send4(10, 11, 12, 13, 100);
    drain("hex_drain");
    check("hex_value_kept", value, exp_value);

    // glitch filter on dig2: short 7 then stable 8
    expect_frame(5, 8, 0, 6, 4'b0000, 1'b1);
    drive(4'b1000, pat7(5), 100);
    drive(4'b0100, pat7(7), 10);
    drive(4'b0100, pat7(8), 20);
    drive(4'b0010, pat7(0), 100);
    drive(4'b0001, pat7(6), 100);
    drain("glitch_drain");
    check("glitch_value", value, exp_value);

    // illegal pattern on dig3
    expect_frame(5, 6, 0, 7, 4'b0010, 1'b1);
    drive(4'b1000, pat7(5), 100);
    drive(4'b0100, pat7(6), 100);
    drive(4'b0010, 7'b0000001, 100);
    drive(4'b0001, pat7(7), 100);
    drain("illegal_drain");

    // overlapping dig1/dig2 must flag errors and not capture dig1
    m0 = n_multi;
    drive(4'b1100, pat7(8), 5);
    drive(4'b0100, pat7(1), 100);
    check("multi_pulses", n_multi - m0, 5);
    f0 = n_frames;
    drive(4'b0010, pat7(2), 100);
    drive(4'b0001, pat7(3), 100);
    check("multi_no_frame", n_frames - f0, 0);
    expect_frame(4, 1, 2, 3, 4'b0000, 1'b1);
    drive(4'b1000, pat7(4), 100);
    drain("multi_drain");
    check("multi_value", value, exp_value);

    // reset during conversion step T+2
    expect_frame(1, 2, 3, 4, 4'b0000, 1'b0);
    drive(4'b1000, pat7(1), 100);
    drive(4'b0100, pat7(2), 100);
    drive(4'b0010, pat7(3), 100);
    drive(4'b0001, pat7(4), 0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    check("rst_mid_frame_seen", seen, 1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    {dig1, dig2, dig3, dig4} = '1;
    {a_l, b_l, c_l, d_l, e_l, f_l, g_l} = '1;
    repeat (3) @(negedge clk);
    check("rst_mid_value", value, 0);
    check("rst_mid_value_valid", value_valid, 0);
    check("rst_mid_A", A, 0);
    rst = 1'b1;
    exp_value = 0;
    repeat (20) @(negedge clk);
    check("rst_mid_value_after", value, 0);

    expect_frame(9, 9, 9, 9, 4'b0000, 1'b1);
    send4(9, 9, 9, 9, 100);
    drain("max_drain");
    check("max_value", value, exp_value);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
